// File: rtl/sram_bank_pkg.sv
// sram_bank_pkg: shared FSM state type, byte width and parity helper for the SRAM bank
package sram_bank_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int BYTE_W = 8;
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/sram_bank_array.sv
// sram_bank_array: single-port byte-enable storage with registered read; even parity per byte under SRAM_BANK_PARITY_EN
// Ports: clk, rst (async, clears read register only), i_en/i_we/i_addr/i_wdata/i_be access, o_rdata registered read;
// with SRAM_BANK_PARITY_EN: i_inj inverts stored parity on write, o_perr flags a parity mismatch on read.
module sram_bank_array
  import sram_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32768,
  parameter int IW     = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [IW-1:0]            i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [DATA_W/BYTE_W-1:0] i_be,
`ifdef SRAM_BANK_PARITY_EN
  input  logic                     i_inj,
  output logic                     o_perr,
`endif
  output logic [DATA_W-1:0]        o_rdata
);
  localparam int NB = DATA_W / BYTE_W;
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_en && i_we)
      for (int i = 0; i < NB; i++)
        if (i_be[i]) r_mem[i_addr][i*BYTE_W +: BYTE_W] <= i_wdata[i*BYTE_W +: BYTE_W];
  // read register is zero outside the response cycle, so write acks and idle cycles read back 0
  always_ff @(posedge clk or posedge rst)
    if (rst) o_rdata <= '0;
    else     o_rdata <= (i_en && !i_we) ? r_mem[i_addr] : '0;
`ifdef SRAM_BANK_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_chk;
  always_comb begin
    w_chk = '0;
    for (int i = 0; i < NB; i++)
      w_chk[i] = byte_parity(r_mem[i_addr][i*BYTE_W +: BYTE_W]) ^ r_par[i_addr][i];
  end
  always_ff @(posedge clk)
    if (i_en && i_we)
      for (int i = 0; i < NB; i++)
        if (i_be[i]) r_par[i_addr][i] <= byte_parity(i_wdata[i*BYTE_W +: BYTE_W]) ^ i_inj;
  always_ff @(posedge clk or posedge rst)
    if (rst) o_perr <= 1'b0;
    else     o_perr <= i_en && !i_we && |w_chk;
`endif
endmodule

// File: rtl/sram_bank.sv
// sram_bank: parametrised synchronous SRAM bank with valid/ready request port, one-cycle response and wait states
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_we/req_addr/req_wdata/req_be request;
// rsp_valid/rsp_rdata response strobe; busy while a request is in flight.
// Optional SRAM_BANK_PARITY_EN adds inj_perr (in) and rsp_perr (out) with per-byte even parity.
module sram_bank
  import sram_bank_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 15,
  parameter int DEPTH       = 32768,
  parameter int WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/BYTE_W-1:0] req_be,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     busy
`ifdef SRAM_BANK_PARITY_EN
  ,
  input  logic                     inj_perr,
  output logic                     rsp_perr
`endif
);
  localparam int NB = DATA_W / BYTE_W;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we, r_ready, r_busy, r_rsp_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_be;
  logic              w_en;
`ifdef SRAM_BANK_PARITY_EN
  logic              r_inj;
`endif
  // out-of-range accesses never reach the array: writes vanish, reads see the zeroed read register
  assign w_en = r_state == ACCESS && r_cnt == '0 && {1'b0, r_addr} < DEPTH_C;
  assign req_ready = r_ready;
  assign busy = r_busy;
  assign rsp_valid = r_rsp_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_ready <= 1'b1;
      r_busy <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_be <= '0;
`ifdef SRAM_BANK_PARITY_EN
      r_inj <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_we <= req_we;
          r_addr <= req_addr;
          r_wdata <= req_wdata;
          r_be <= req_be;
`ifdef SRAM_BANK_PARITY_EN
          r_inj <= inj_perr;
`endif
          r_cnt <= 4'(WAIT_STATES);
          r_state <= ACCESS;
          r_ready <= 1'b0;
          r_busy <= 1'b1;
        end
        ACCESS: if (r_cnt != '0) r_cnt <= r_cnt - 4'd1;
          else begin
            r_state <= RESP;
            r_rsp_valid <= 1'b1;
          end
        RESP: begin
          r_state <= IDLE;
          r_rsp_valid <= 1'b0;
          r_ready <= 1'b1;
          r_busy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  sram_bank_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_en),
    .i_we    (r_we),
    .i_addr  (r_addr[IW-1:0]),
    .i_wdata (r_wdata),
    .i_be    (r_be),
`ifdef SRAM_BANK_PARITY_EN
    .i_inj   (r_inj),
    .o_perr  (rsp_perr),
`endif
    .o_rdata (rsp_rdata)
  );
endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank: scoreboard bench for sram_bank with 32-bit data, 1000 words and 3 wait states
module tb_sram_bank;
  localparam int DW = 32, AW = 15, DEPTH = 1000, WS = 3;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0] req_be = '0;
  logic req_ready, rsp_valid, busy;
  logic [DW-1:0] rsp_rdata;
`ifdef SRAM_BANK_PARITY_EN
  logic inj_perr = 0;
  logic rsp_perr;
`endif
  typedef struct {logic [DW-1:0] d; logic p; int acc;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, last_acc = 0, brun = 0;

  sram_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy)
`ifdef SRAM_BANK_PARITY_EN
    , .inj_perr(inj_perr), .rsp_perr(rsp_perr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) brun = 0;
    else begin
      brun = busy ? brun + 1 : 0;
      if (rsp_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp got=rsp_valid want=none at cyc %0d", cyc);
        end else begin
          total--;
          e = sb.pop_front();
          chk("rdata", rsp_rdata, e.d);
          chk("latency", cyc - e.acc, WS + 1);
          chk("busy_cycles", brun, WS + 2);
          chk("ready_in_rsp", req_ready, 0);
`ifdef SRAM_BANK_PARITY_EN
          chk("perr", rsp_perr, e.p);
`endif
        end
      end else chk("rdata_idle", rsp_rdata, 0);
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] be, input logic [DW-1:0] exp, input logic inj,
                       input logic ep, input bit b2b);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
`ifdef SRAM_BANK_PARITY_EN
    inj_perr = inj;
`endif
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) begin
      total++; bad++;
      $display("FAIL accept_timeout got=no_ready want=ready addr=%0h", a);
      req_valid = 0;
      return;
    end
    if (b2b) chk("issue_interval", cyc + 1 - last_acc, WS + 3);
    last_acc = cyc + 1;
    sb.push_back('{exp, ep, cyc + 1});
    @(posedge clk);
    #1;
    req_valid = 0; req_we = ~req_we; req_addr = AW'($urandom); req_wdata = $urandom; req_be = 4'($urandom);
`ifdef SRAM_BANK_PARITY_EN
    inj_perr = ~inj_perr;
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) begin
      total++; bad++;
      $display("FAIL idle_timeout got=pending=%0d want=0", sb.size());
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 0;
    issue(1, 15'h0010, 32'h12345678, 4'hF, 0, 0, 0, 0);
    issue(0, 15'h0010, 0, 4'h0, 32'h12345678, 0, 0, 1);
    issue(1, 15'd999, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1);
    issue(1, 15'd999, 32'h00000011, 4'h1, 0, 0, 0, 1);
    issue(0, 15'd999, 0, 4'hF, 32'hDEADBE11, 0, 0, 1);
    issue(1, 15'd999, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 1);
    issue(1, 15'd999, 32'hAABBCCDD, 4'b1010, 0, 0, 0, 1);
    issue(0, 15'd999, 0, 4'h0, 32'hAAADCC11, 0, 0, 1);
    issue(1, 15'd1000, 32'h000000AA, 4'hF, 0, 0, 0, 1);
    issue(0, 15'd1000, 0, 4'h0, 0, 0, 0, 1);
    issue(0, 15'd999, 0, 4'h0, 32'hAAADCC11, 0, 0, 1);
    issue(0, 15'h7FFF, 0, 4'h0, 0, 0, 0, 1);
    issue(1, 15'h0005, 32'h01020304, 4'hF, 0, 0, 0, 1);
    issue(0, 15'h0005, 0, 4'h0, 32'h01020304, 0, 0, 1);
    wait_idle();
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 15'h0005; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1 rst = 0;
    issue(0, 15'h0005, 0, 4'h0, 32'h01020304, 0, 0, 0);
`ifdef SRAM_BANK_PARITY_EN
    issue(1, 15'h0007, 32'h5A5A5A5A, 4'hF, 0, 1, 0, 1);
    issue(0, 15'h0007, 0, 4'h0, 32'h5A5A5A5A, 0, 1, 1);
    issue(1, 15'h0007, 32'h5A5A5A5A, 4'hF, 0, 0, 0, 1);
    issue(0, 15'h0007, 0, 4'h0, 32'h5A5A5A5A, 0, 0, 1);
`endif
    wait_idle();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
